// File: rtl/ct_memshade_pkg.sv
// ---------------------------------------------------------------------------
// ct_memshade_pkg
// Shared definitions for the memshade SRAM wrappers (single- and dual-port).
//   memshade_state_e : taint-sweep controller states
//   f_taint_wr       : per-bit taint update rule for one access
// ---------------------------------------------------------------------------
package ct_memshade_pkg;

  // INIT  : taint array is being cleared one entry per cycle
  // READY : sweep finished, accesses are accepted; left only by reset
  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } memshade_state_e;

  // Taint update for a single bit of the addressed entry.
  // Returns {write_enable, write_value}.
  //   - a real, unmasked write stores the data taint, widened by any taint
  //     on the mask bit or on the control/address path
  //   - otherwise a tainted mask bit or tainted control means the bit may
  //     have been written, so it is forced to 1 (conservative)
  //   - otherwise the stored taint bit is left alone
  // The caller gates the result with "access or tainted chip enable".
  function automatic logic [1:0] f_taint_wr(
    input logic wen,
    input logic wen_t0,
    input logic d_t0,
    input logic wr,
    input logic ct
  );
    logic [1:0] r;
    r = 2'b00;
    if (!wen && wr) begin
      r = {1'b1, (d_t0 | wen_t0 | ct)};
    end else if (wen_t0 || ct) begin
      r = 2'b11;
    end
    return r;
  endfunction

endpackage

// File: rtl/ct_f_spsram_param.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_param
// Plain bit-masked single-port SRAM with 1-cycle registered read.
// Used twice by ct_spsram_param_memshade: once for data, once for taint.
//
// Ports
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (read register only)
//   rd_en  : read strobe; q loads mem[addr] on the next edge
//   wr_en  : write strobe; bits with wmask=1 take d
//   addr   : entry address
//   wmask  : per-bit write enable, active high
//   d      : write data
//   q      : registered read data; holds when rd_en=0
//
// A read and a write to the same entry in one cycle return the old
// contents (read-first). Addresses >= DEPTH drop writes and read as 0.
// The array itself is never reset.
// ---------------------------------------------------------------------------
module ct_f_spsram_param #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 54,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wmask,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range;

  // DEPTH may be non-power-of-two, so the top of the address space can
  // fall outside the array.
  assign in_range = (32'(addr) < 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_en && in_range) begin
      mem[addr] <= (mem[addr] & ~wmask) | (d & wmask);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (rd_en) begin
      q <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/ct_spsram_param_memshade.sv
// ---------------------------------------------------------------------------
// ct_spsram_param_memshade
// Parametrised single-port SRAM with a taint shadow array. Read taint is
// taken from the stored taint plus any taint on the control/address path.
// After reset the taint array is cleared by a sweep, one entry per cycle;
// the data array is never reset.
//
// Access protocol: there is no handshake. An access is a single cycle with
// CEN=0 and is accepted only while INIT_DONE=1; accesses presented while
// INIT_DONE=0 are silently dropped (no data or taint write, Q/Q_t0 hold).
//
// Ports
//   CLK, RST          : clock (rising edge), async active-high reset
//   A, A_t0           : address and its taint
//   CEN, CEN_t0       : chip enable (active low) and its taint
//   GWEN, GWEN_t0     : global write enable (active low) and its taint
//   WEN, WEN_t0       : per-bit write enable (active low) and its taint
//   D, D_t0           : write data and its taint
//   Q, Q_t0           : read data and read taint (latency 1, or 2 with OUT_REG)
//   INIT_DONE         : taint sweep complete
//   dbg_state         : sweep controller state, for observation only
// ---------------------------------------------------------------------------
module ct_spsram_param_memshade
  import ct_memshade_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 54,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int OUT_REG    = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [ADDR_WIDTH-1:0] A_t0,
  input  logic                  CEN,
  input  logic                  CEN_t0,
  input  logic                  GWEN,
  input  logic                  GWEN_t0,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] WEN_t0,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] D_t0,
  output logic [DATA_WIDTH-1:0] Q,
  output logic [DATA_WIDTH-1:0] Q_t0,
  output logic                  INIT_DONE,
  output memshade_state_e       dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

  memshade_state_e       state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  init_done;

  logic                  in_init;
  logic                  ready;
  logic                  acc;
  logic                  rd;
  logic                  wr;
  logic                  ct;
  logic                  oob;

  logic [DATA_WIDTH-1:0] t_mask;
  logic [DATA_WIDTH-1:0] t_data;

  logic [ADDR_WIDTH-1:0] t_addr;
  logic                  t_wr_en;
  logic [DATA_WIDTH-1:0] t_wmask;
  logic [DATA_WIDTH-1:0] t_wdata;

  logic [DATA_WIDTH-1:0] d_q;
  logic [DATA_WIDTH-1:0] t_q;
  logic                  rd_force_q;
  logic [DATA_WIDTH-1:0] q_raw;
  logic [DATA_WIDTH-1:0] qt_raw;

  // -------------------------------------------------------------------------
  // Sweep controller. The entry written on a cycle is the current cnt;
  // when the last entry is written the state flips and INIT_DONE rises
  // together on the same edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (cnt == CNT_LAST) begin
            state     <= READY;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READY: begin
          state     <= READY;
          init_done <= 1'b1;
        end
        default: begin
          state     <= INIT;
          cnt       <= '0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  assign INIT_DONE = init_done;
  assign dbg_state = state;

  // -------------------------------------------------------------------------
  // Access decode (only while READY)
  // -------------------------------------------------------------------------
  assign in_init = (state == INIT);
  assign ready   = (state == READY);
  assign acc     = ready & ~CEN;
  assign rd      = acc & GWEN;
  assign wr      = acc & ~GWEN;
  assign ct      = CEN_t0 | GWEN_t0 | (|A_t0);
  assign oob     = (32'(A) >= 32'(DEPTH));

  // Per-bit taint write mask and value for the addressed entry.
  always_comb begin
    logic [1:0] tw;
    tw     = 2'b00;
    t_mask = '0;
    t_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      tw        = f_taint_wr(WEN[i], WEN_t0[i], D_t0[i], wr, ct);
      t_mask[i] = tw[1];
      t_data[i] = tw[0];
    end
  end

  // Taint array port: owned by the sweep during INIT, by the access path
  // afterwards. A tainted idle cycle still counts as a possible access.
  assign t_addr  = in_init ? cnt : A;
  assign t_wr_en = in_init | (ready & (acc | CEN_t0));
  assign t_wmask = in_init ? {DATA_WIDTH{1'b1}} : t_mask;
  assign t_wdata = in_init ? '0 : t_data;

  ct_f_spsram_param #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_data_mem (
    .clk   (CLK),
    .rst   (RST),
    .rd_en (rd),
    .wr_en (wr),
    .addr  (A),
    .wmask (~WEN),
    .d     (D),
    .q     (d_q)
  );

  ct_f_spsram_param #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_taint_mem (
    .clk   (CLK),
    .rst   (RST),
    .rd_en (rd),
    .wr_en (t_wr_en),
    .addr  (t_addr),
    .wmask (t_wmask),
    .d     (t_wdata),
    .q     (t_q)
  );

  // Remembers, for the last read, whether the whole read taint must be
  // forced to ones: tainted control/address, or an address past DEPTH.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_force_q <= 1'b0;
    end else if (rd) begin
      rd_force_q <= ct | oob;
    end
  end

  assign q_raw  = d_q;
  assign qt_raw = t_q | {DATA_WIDTH{rd_force_q}};

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q_r;
      logic [DATA_WIDTH-1:0] qt_r;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          q_r  <= '0;
          qt_r <= '0;
        end else begin
          q_r  <= q_raw;
          qt_r <= qt_raw;
        end
      end
      assign Q    = q_r;
      assign Q_t0 = qt_r;
    end else begin : g_no_out_reg
      assign Q    = q_raw;
      assign Q_t0 = qt_raw;
    end
  endgenerate

endmodule

// File: tb/tb_ct_spsram_param_memshade.sv
// ---------------------------------------------------------------------------
// Bench for ct_spsram_param_memshade. Three instances share one stimulus:
//   u0 : defaults (512 entries, latency 1)
//   u1 : OUT_REG=1 (latency 2)
//   u2 : DEPTH=300
// A behavioural model (arrays of entries, applied per access) predicts the
// outputs; u1 is checked against u0's prediction delayed through exp_q.
// ---------------------------------------------------------------------------
module tb_ct_spsram_param_memshade;
  import ct_memshade_pkg::*;

  localparam int AW = 9;
  localparam int DW = 54;
  localparam int DEP0 = 512;
  localparam int DEP2 = 300;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic RST;
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- DUT signals ----------------
  logic [AW-1:0] A, A_t0;
  logic          CEN, CEN_t0, GWEN, GWEN_t0;
  logic [DW-1:0] WEN, WEN_t0, D, D_t0;

  logic [DW-1:0] Q0, Qt0, Q1, Qt1, Q2, Qt2;
  logic          done0, done1, done2;
  memshade_state_e st0, st1, st2;

  ct_spsram_param_memshade u0 (
    .CLK(CLK), .RST(RST), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
    .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D), .D_t0(D_t0),
    .Q(Q0), .Q_t0(Qt0), .INIT_DONE(done0), .dbg_state(st0)
  );

  ct_spsram_param_memshade #(.OUT_REG(1)) u1 (
    .CLK(CLK), .RST(RST), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
    .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D), .D_t0(D_t0),
    .Q(Q1), .Q_t0(Qt1), .INIT_DONE(done1), .dbg_state(st1)
  );

  ct_spsram_param_memshade #(.DEPTH(DEP2)) u2 (
    .CLK(CLK), .RST(RST), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
    .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D), .D_t0(D_t0),
    .Q(Q2), .Q_t0(Qt2), .INIT_DONE(done2), .dbg_state(st2)
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  // model index 0 -> 512-entry memory (u0, u1), index 1 -> 300-entry (u2)
  logic [DW-1:0] m_data  [2][512];
  bit            m_known [2][512];
  logic [DW-1:0] m_taint [2][512];
  logic [DW-1:0] eq  [2];
  logic [DW-1:0] eqt [2];
  bit            ev  [2];
  int            edges;

  // {known, taint, data} of u0's prediction, one cycle behind for u1
  logic [2*DW:0] exp_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand54();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Apply the current inputs as one clock edge to model k.
  function automatic void model_edge(input int k, input int depth);
    int ai;
    bit acc, rd, wr, ct, oob;
    ai  = int'(A);
    acc = !CEN;
    rd  = acc && GWEN;
    wr  = acc && !GWEN;
    ct  = CEN_t0 || GWEN_t0 || (A_t0 != '0);
    oob = (ai >= depth);
    if (edges <= depth) return;  // still sweeping: access dropped
    if (rd) begin
      if (oob) begin
        eq[k]  = '0;
        eqt[k] = '1;
        ev[k]  = 1'b1;
      end else begin
        eq[k]  = m_data[k][ai];
        eqt[k] = m_taint[k][ai] | (ct ? '1 : '0);
        ev[k]  = m_known[k][ai];
      end
    end
    if (!oob) begin
      if (wr) begin
        for (int i = 0; i < DW; i++)
          if (!WEN[i]) m_data[k][ai][i] = D[i];
        if (WEN == '0) m_known[k][ai] = 1'b1;
      end
      if (acc || CEN_t0) begin
        for (int i = 0; i < DW; i++) begin
          if (!WEN[i] && wr) m_taint[k][ai][i] = D_t0[i] | WEN_t0[i] | ct;
          else if (WEN_t0[i] || ct) m_taint[k][ai][i] = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    edges = 0;
    for (int k = 0; k < 2; k++) begin
      eq[k]  = '0;
      eqt[k] = '0;
      ev[k]  = 1'b1;
      for (int a = 0; a < 512; a++) m_taint[k][a] = '0;
    end
    exp_q.delete();
    exp_q.push_back({1'b1, {DW{1'b0}}, {DW{1'b0}}});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drv_idle();
    A = '0; A_t0 = '0; CEN = 1'b1; CEN_t0 = 1'b0; GWEN = 1'b1; GWEN_t0 = 1'b0;
    WEN = '1; WEN_t0 = '0; D = '0; D_t0 = '0;
  endtask

  task automatic drv_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] wen, input logic [DW-1:0] dt,
                        input logic [AW-1:0] at);
    drv_idle();
    A = a; A_t0 = at; CEN = 1'b0; GWEN = 1'b0; WEN = wen; D = d; D_t0 = dt;
  endtask

  task automatic drv_rd(input logic [AW-1:0] a, input logic [AW-1:0] at);
    drv_idle();
    A = a; A_t0 = at; CEN = 1'b0; GWEN = 1'b1;
  endtask

  // One clock: model the edge, then compare every output at the falling edge.
  task automatic tick();
    logic [2*DW:0] e1;
    @(posedge CLK);
    edges++;
    model_edge(0, DEP0);
    model_edge(1, DEP2);
    e1 = exp_q.pop_front();
    exp_q.push_back({ev[0], eqt[0], eq[0]});
    @(negedge CLK);
    chkb("done_u0", done0, edges >= DEP0);
    chkb("done_u1", done1, edges >= DEP0);
    chkb("done_u2", done2, edges >= DEP2);
    chkb("state_u0", st0 == READY, edges >= DEP0);
    chkb("state_u2", st2 == READY, edges >= DEP2);
    if (ev[0]) chk("q_u0", Q0, eq[0]);
    chk("qt_u0", Qt0, eqt[0]);
    if (e1[2*DW]) chk("q_u1", Q1, e1[DW-1:0]);
    chk("qt_u1", Qt1, e1[2*DW-1:DW]);
    if (ev[1]) chk("q_u2", Q2, eq[1]);
    chk("qt_u2", Qt2, eqt[1]);
  endtask

  // Asserted at a falling edge; INIT_DONE and outputs must drop at once.
  task automatic do_reset();
    RST = 1'b1;
    #1;
    chkb("rst_done_u0", done0, 1'b0);
    chkb("rst_done_u1", done1, 1'b0);
    chkb("rst_done_u2", done2, 1'b0);
    chk("rst_q_u0", Q0, '0);
    chk("rst_qt_u0", Qt0, '0);
    chk("rst_q_u1", Q1, '0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  // Sweep: checks the exact INIT_DONE edge for both depths.
  task automatic sweep(input int first);
    for (int c = first; c <= DEP0; c++) begin
      tick();
      if (c == DEP2 - 1) chkb("u2_done_at_299", done2, 1'b0);
      if (c == DEP2)     chkb("u2_done_at_300", done2, 1'b1);
      if (c == DEP0 - 1) chkb("u0_done_at_511", done0, 1'b0);
      if (c == DEP0)     chkb("u0_done_at_512", done0, 1'b1);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] at_w;
    logic [AW-1:0] at_r;
    logic [DW-1:0] wen;
    logic [DW-1:0] d;
    logic [DW-1:0] dt;
    logic [DW-1:0] exp_q;
    logic [DW-1:0] exp_qt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{9'h005, 9'h000, 9'h000, 54'h0, 54'h2A5A5A5A5A5A5A, 54'h0,
                54'h2A5A5A5A5A5A5A, 54'h0};
    vecs[1] = '{9'h010, 9'h000, 9'h000, 54'h0, 54'h0, 54'h0, 54'h0, 54'h0};
    vecs[2] = '{9'h010, 9'h000, 9'h000, ~54'hFF, 54'h3FFFFFFFFFFFFF, 54'h0F,
                54'hFF, 54'h0F};
    vecs[3] = '{9'h020, 9'h001, 9'h000, 54'h0, 54'h123, 54'h0,
                54'h123, 54'h3FFFFFFFFFFFFF};
    vecs[4] = '{9'h030, 9'h000, 9'h100, 54'h0, 54'h55, 54'h0,
                54'h55, 54'h3FFFFFFFFFFFFF};

    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 512; a++) begin
        m_data[k][a]  = '0;
        m_known[k][a] = 1'b0;
      end

    drv_idle();
    do_reset();
    sweep(1);

    // top entry of u0 is clean after the sweep; for u2 it is out of range
    drv_rd(9'h1FF, 9'h000);
    tick();
    chk("rd1ff_qt_u0", Qt0, '0);
    chk("rd1ff_q_u2", Q2, '0);
    chk("rd1ff_qt_u2", Qt2, '1);

    // write then read the next cycle
    for (int v = 0; v < 5; v++) begin
      drv_wr(vecs[v].a, vecs[v].d, vecs[v].wen, vecs[v].dt, vecs[v].at_w);
      tick();
      drv_rd(vecs[v].a, vecs[v].at_r);
      tick();
      chk($sformatf("vec%0d_q_u0", v), Q0, vecs[v].exp_q);
      chk($sformatf("vec%0d_qt_u0", v), Qt0, vecs[v].exp_qt);
      chk($sformatf("vec%0d_q_u2", v), Q2, vecs[v].exp_q);
      chk($sformatf("vec%0d_qt_u2", v), Qt2, vecs[v].exp_qt);
      drv_idle();
      tick();
      chk($sformatf("vec%0d_q_u1", v), Q1, vecs[v].exp_q);
      chk($sformatf("vec%0d_qt_u1", v), Qt1, vecs[v].exp_qt);
      chk($sformatf("vec%0d_hold_u0", v), Q0, vecs[v].exp_q);
    end

    // entry 300: out of range only for u2
    drv_wr(9'd300, 54'h1234567, '0, '0, '0);
    tick();
    drv_rd(9'd300, 9'h000);
    tick();
    chk("oob_q_u2", Q2, '0);
    chk("oob_qt_u2", Qt2, '1);
    chk("oob_q_u0", Q0, 54'h1234567);
    chk("oob_qt_u0", Qt0, '0);

    // tainted idle cycle taints the whole entry but leaves data alone
    drv_idle();
    A = 9'h005; CEN_t0 = 1'b1;
    tick();
    drv_rd(9'h005, 9'h000);
    tick();
    chk("tidle_q_u0", Q0, 54'h2A5A5A5A5A5A5A);
    chk("tidle_qt_u0", Qt0, '1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int op, sel;
      logic [AW-1:0] a;
      op  = $urandom_range(0, 9);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = AW'($urandom_range(0, 7));
        1:       a = AW'($urandom_range(296, 303));
        2:       a = 9'h1FF;
        default: a = AW'($urandom_range(0, 511));
      endcase
      drv_idle();
      A = a;
      if ($urandom_range(0, 7) == 0) A_t0 = AW'($urandom_range(1, 511));
      if ($urandom_range(0, 9) == 0) GWEN_t0 = 1'b1;
      if ($urandom_range(0, 9) == 0) CEN_t0 = 1'b1;
      if ($urandom_range(0, 5) == 0) WEN_t0 = rand54() & rand54();
      D_t0 = ($urandom_range(0, 1) == 0) ? '0 : rand54();
      if (op >= 3) begin
        CEN  = 1'b0;
        GWEN = (op <= 5);
        D    = rand54();
        WEN  = ($urandom_range(0, 2) == 0) ? rand54() : '0;
      end
      tick();
    end

    // reset from READY, a second reset mid-sweep, and a dropped write
    drv_wr(9'h007, 54'hABC, '0, '0, '0);
    tick();
    drv_idle();
    tick();
    do_reset();
    for (int c = 1; c <= 100; c++) tick();
    chkb("mid_sweep_done", done0, 1'b0);
    do_reset();
    drv_wr(9'h007, 54'h111, '0, 54'h3, '0);
    tick();
    drv_idle();
    sweep(2);
    drv_rd(9'h007, 9'h000);
    tick();
    chk("restart_q_u0", Q0, 54'hABC);
    chk("restart_qt_u0", Qt0, '0);
    drv_rd(9'h020, 9'h000);
    tick();
    chk("restart_qt20_u0", Qt0, '0);
    drv_idle();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
